// File: rtl/sr_cmd_pkg.sv
// Shared types and defaults for the SR command generator.
// Holds the FSM state encoding, parameter defaults and a counter-width helper.
package sr_cmd_pkg;

   localparam int DEB_CYC_DEF      = 4;
   localparam int HOLDOFF_CYC_DEF  = 2;
   localparam bit SET_PRIORITY_DEF = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      SET_PULSE,
      CLR_PULSE,
      HOLDOFF
   } state_t;

   // Width able to hold 0..n, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/sr_debounce.sv
// One request channel: 2-flop synchronizer, stability counter and
// a registered pulse on each rising edge of the debounced level.
module sr_debounce
   import sr_cmd_pkg::*;
#(
   parameter int DEB_CYC = DEB_CYC_DEF
)
(
   input  logic clk,
   input  logic rst,
   input  logic req_async,
   output logic rise
);

   localparam int            CW       = cnt_width(DEB_CYC);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

   logic [1:0]    sync_ff;
   logic [CW-1:0] cnt;
   logic          deb_lvl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_ff <= '0;
      end else begin
         sync_ff <= {sync_ff[0], req_async};
      end
   end

   // The level flips once the synchronized input has disagreed with it for DEB_CYC edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         deb_lvl <= 1'b0;
         rise    <= 1'b0;
      end else begin
         rise <= 1'b0;
         if (sync_ff[1] == deb_lvl) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt     <= '0;
            deb_lvl <= ~deb_lvl;
            rise    <= ~deb_lvl;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns debounced set/clear requests into one-cycle S/R pulses for a
// downstream SR flip-flop, with arbitration, pending flags and holdoff.
module sr_cmd_gen
   import sr_cmd_pkg::*;
#(
   parameter int DEB_CYC      = DEB_CYC_DEF,
   parameter int HOLDOFF_CYC  = HOLDOFF_CYC_DEF,
   parameter bit SET_PRIORITY = SET_PRIORITY_DEF
)
(
   input  logic clk,
   input  logic rst,
   input  logic set_req_async,
   input  logic clr_req_async,
   output logic s_out,
   output logic r_out,
   output logic busy,
   output logic conflict
);

   localparam int            HW          = cnt_width(HOLDOFF_CYC);
   localparam logic [HW-1:0] HOLD_LAST   = HW'((HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0);
   localparam state_t        AFTER_PULSE = (HOLDOFF_CYC > 0) ? HOLDOFF : IDLE;

   state_t        state;
   logic          set_ev;
   logic          clr_ev;
   logic          set_pend;
   logic          clr_pend;
   logic [HW-1:0] hold_cnt;
   logic          set_any;
   logic          clr_any;
   logic          take_set;

   sr_debounce #(.DEB_CYC(DEB_CYC)) u_set_deb (
      .clk       (clk),
      .rst       (rst),
      .req_async (set_req_async),
      .rise      (set_ev)
   );

   sr_debounce #(.DEB_CYC(DEB_CYC)) u_clr_deb (
      .clk       (clk),
      .rst       (rst),
      .req_async (clr_req_async),
      .rise      (clr_ev)
   );

   assign set_any  = set_ev | set_pend;
   assign clr_any  = clr_ev | clr_pend;
   assign take_set = set_any & (~clr_any | SET_PRIORITY);

   // Outputs are decided on the transition so they are plain flops, never decoded from state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         set_pend <= 1'b0;
         clr_pend <= 1'b0;
         hold_cnt <= '0;
         s_out    <= 1'b0;
         r_out    <= 1'b0;
         busy     <= 1'b0;
         conflict <= 1'b0;
      end else begin
         s_out    <= 1'b0;
         r_out    <= 1'b0;
         conflict <= 1'b0;
         if (state != IDLE) begin
            set_pend <= set_pend | set_ev;
            clr_pend <= clr_pend | clr_ev;
         end
         case (state)
            IDLE: begin
               if (set_any | clr_any) begin
                  set_pend <= 1'b0;
                  clr_pend <= 1'b0;
                  conflict <= set_any & clr_any;
                  busy     <= 1'b1;
                  if (take_set) begin
                     state <= SET_PULSE;
                     s_out <= 1'b1;
                  end else begin
                     state <= CLR_PULSE;
                     r_out <= 1'b1;
                  end
               end
            end
            SET_PULSE, CLR_PULSE: begin
               state    <= AFTER_PULSE;
               hold_cnt <= '0;
               busy     <= (HOLDOFF_CYC > 0);
            end
            HOLDOFF: begin
               if (hold_cnt == HOLD_LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sr_cmd_gen.sv
// Bench for sr_cmd_gen: a default instance and a fast instance
// (DEB_CYC=1, HOLDOFF_CYC=0, clear wins) share the same stimulus.
module tb_sr_cmd_gen;

   localparam int NI = 2;

   logic          clk;
   logic          rst;
   logic          set_req_async;
   logic          clr_req_async;
   logic [NI-1:0] s_out;
   logic [NI-1:0] r_out;
   logic [NI-1:0] busy;
   logic [NI-1:0] conflict;

   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   sr_cmd_gen dut0 (
      .clk           (clk),
      .rst           (rst),
      .set_req_async (set_req_async),
      .clr_req_async (clr_req_async),
      .s_out         (s_out[0]),
      .r_out         (r_out[0]),
      .busy          (busy[0]),
      .conflict      (conflict[0])
   );

   sr_cmd_gen #(.DEB_CYC(1), .HOLDOFF_CYC(0), .SET_PRIORITY(1'b0)) dut1 (
      .clk           (clk),
      .rst           (rst),
      .set_req_async (set_req_async),
      .clr_req_async (clr_req_async),
      .s_out         (s_out[1]),
      .r_out         (r_out[1]),
      .busy          (busy[1]),
      .conflict      (conflict[1])
   );

   // Reference: the debounced level follows the input once the last DEB_CYC synchronized
   // samples all disagree with it; pulses are tracked by edge timestamps, not states.
   int m_deb_cyc [NI] = '{4, 1};
   int m_hold    [NI] = '{2, 0};
   bit m_setpri  [NI] = '{1'b1, 1'b0};

   bit raw_s[$];
   bit raw_c[$];
   bit seen_s[$];
   bit seen_c[$];
   bit deb  [NI][2];
   bit rose [NI][2];
   bit pend [NI][2];
   int free_edge  [NI];
   int last_pulse [NI];
   bit last_is_set[NI];
   bit last_conf  [NI];
   int k = 0;

   int rel_edge;
   int obs_s[NI];
   int obs_r[NI];
   int obs_c[NI];
   int obs_b[NI];
   int first_s[NI];
   int first_r[NI];

   function automatic void model_reset();
      raw_s.delete();
      raw_c.delete();
      seen_s.delete();
      seen_c.delete();
      repeat (2) begin
         raw_s.push_back(1'b0);
         raw_c.push_back(1'b0);
      end
      for (int i = 0; i < NI; i++) begin
         for (int ch = 0; ch < 2; ch++) begin
            deb[i][ch]  = 1'b0;
            rose[i][ch] = 1'b0;
            pend[i][ch] = 1'b0;
         end
         free_edge[i]   = 0;
         last_pulse[i]  = -1000;
         last_is_set[i] = 1'b0;
         last_conf[i]   = 1'b0;
      end
   endfunction

   function automatic bit window_differs(input int ch, input int d, input bit lvl);
      for (int j = 0; j < d; j++) begin
         int idx;
         bit v;
         idx = ((ch == 0) ? seen_s.size() : seen_c.size()) - 1 - j;
         v   = 1'b0;
         if (idx >= 0) v = (ch == 0) ? seen_s[idx] : seen_c[idx];
         if (v == lvl) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic void model_edge(input bit in_s, input bit in_c, input bit in_rst);
      k++;
      if (in_rst) begin
         model_reset();
         return;
      end
      raw_s.push_back(in_s);
      raw_c.push_back(in_c);
      seen_s.push_back(raw_s[raw_s.size() - 3]);
      seen_c.push_back(raw_c[raw_c.size() - 3]);
      if (raw_s.size() > 4) begin
         void'(raw_s.pop_front());
         void'(raw_c.pop_front());
      end
      if (seen_s.size() > 16) begin
         void'(seen_s.pop_front());
         void'(seen_c.pop_front());
      end
      for (int i = 0; i < NI; i++) begin
         bit ev_s;
         bit ev_c;
         bit a;
         bit b;
         ev_s = rose[i][0];
         ev_c = rose[i][1];
         if (k >= free_edge[i]) begin
            a = ev_s | pend[i][0];
            b = ev_c | pend[i][1];
            if (a | b) begin
               last_pulse[i]  = k;
               last_conf[i]   = a & b;
               last_is_set[i] = (a & b) ? m_setpri[i] : a;
               free_edge[i]   = k + m_hold[i] + 2;
               pend[i][0]     = 1'b0;
               pend[i][1]     = 1'b0;
            end
         end else begin
            pend[i][0] = pend[i][0] | ev_s;
            pend[i][1] = pend[i][1] | ev_c;
         end
         for (int ch = 0; ch < 2; ch++) begin
            rose[i][ch] = 1'b0;
            if (window_differs(ch, m_deb_cyc[i], deb[i][ch])) begin
               deb[i][ch]  = ~deb[i][ch];
               rose[i][ch] = deb[i][ch];
            end
         end
      end
   endfunction

   function automatic bit exp_s(input int i);
      return (last_pulse[i] == k) && last_is_set[i];
   endfunction

   function automatic bit exp_r(input int i);
      return (last_pulse[i] == k) && !last_is_set[i];
   endfunction

   function automatic bit exp_b(input int i);
      return (k >= last_pulse[i]) && (k <= last_pulse[i] + m_hold[i]);
   endfunction

   function automatic bit exp_c(input int i);
      return (last_pulse[i] == k) && last_conf[i];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, $signed(actual), $signed(expected));
      end
   endtask

   task automatic applyStimulus(input bit s, input bit c);
      set_req_async = s;
      clr_req_async = c;
   endtask

   task automatic clearObs();
      rel_edge = 0;
      for (int i = 0; i < NI; i++) begin
         obs_s[i]   = 0;
         obs_r[i]   = 0;
         obs_c[i]   = 0;
         obs_b[i]   = 0;
         first_s[i] = -1;
         first_r[i] = -1;
      end
   endtask

   // One clock: update the model at the edge, compare every output just after it.
   task automatic tick();
      @(posedge clk);
      model_edge(set_req_async, clr_req_async, rst);
      #1;
      rel_edge++;
      for (int i = 0; i < NI; i++) begin
         checkOutput($sformatf("s_out%0d", i), s_out[i], exp_s(i));
         checkOutput($sformatf("r_out%0d", i), r_out[i], exp_r(i));
         checkOutput($sformatf("busy%0d", i), busy[i], exp_b(i));
         checkOutput($sformatf("conflict%0d", i), conflict[i], exp_c(i));
         checkOutput($sformatf("s_and_r%0d", i), s_out[i] & r_out[i], 1'b0);
         if (s_out[i]) begin
            obs_s[i]++;
            if (first_s[i] < 0) first_s[i] = rel_edge;
         end
         if (r_out[i]) begin
            obs_r[i]++;
            if (first_r[i] < 0) first_r[i] = rel_edge;
         end
         if (conflict[i]) obs_c[i]++;
         if (busy[i]) obs_b[i]++;
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      clearObs();
   endtask

   typedef struct {
      int set_on;
      int set_len;
      int clr_on;
      int clr_len;
      int exp_s;
      int exp_r;
      int exp_conf;
      int exp_first_s;
      int exp_first_r;
      int exp_busy;
   } vec_t;

   vec_t vecs[9];

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0);
      model_reset();
      clearObs();

      // Expectations for the default instance, edges counted from reset release.
      vecs[0] = '{1, 20, 0,  0, 1, 0, 0,  7, -1, 3};
      vecs[1] = '{1,  3, 0,  0, 0, 0, 0, -1, -1, 0};
      vecs[2] = '{1,  4, 0,  0, 1, 0, 0,  7, -1, 3};
      vecs[3] = '{1, 20, 1, 20, 1, 0, 1,  7, -1, 3};
      vecs[4] = '{1, 20, 2, 20, 1, 1, 0,  7, 11, 6};
      vecs[5] = '{0,  0, 1, 20, 0, 1, 0, -1,  7, 3};
      vecs[6] = '{1, 20, 5, 20, 1, 1, 0,  7, 11, 6};
      vecs[7] = '{1, 20, 3, 20, 1, 1, 0,  7, 11, 6};
      vecs[8] = '{4, 20, 1, 20, 1, 1, 0, 11,  7, 6};

      for (int v = 0; v < 9; v++) begin
         doReset();
         for (int e = 1; e <= 40; e++) begin
            applyStimulus(e >= vecs[v].set_on && e < vecs[v].set_on + vecs[v].set_len,
                          e >= vecs[v].clr_on && e < vecs[v].clr_on + vecs[v].clr_len);
            tick();
         end
         checkOutput($sformatf("v%0d_s_count", v), obs_s[0], vecs[v].exp_s);
         checkOutput($sformatf("v%0d_r_count", v), obs_r[0], vecs[v].exp_r);
         checkOutput($sformatf("v%0d_conflicts", v), obs_c[0], vecs[v].exp_conf);
         checkOutput($sformatf("v%0d_first_s", v), first_s[0], vecs[v].exp_first_s);
         checkOutput($sformatf("v%0d_first_r", v), first_r[0], vecs[v].exp_first_r);
         checkOutput($sformatf("v%0d_busy_cycles", v), obs_b[0], vecs[v].exp_busy);
      end

      // Reset during holdoff with a clear pending: outputs drop at once, nothing afterwards.
      doReset();
      for (int e = 1; e <= 8; e++) begin
         applyStimulus(1'b1, e >= 2);
         tick();
      end
      checkOutput("hold_busy_before_rst", busy[0], 1'b1);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0);
      #1;
      checkOutput("rst_async_s", s_out[0], 1'b0);
      checkOutput("rst_async_r", r_out[0], 1'b0);
      checkOutput("rst_async_busy", busy[0], 1'b0);
      checkOutput("rst_async_conflict", conflict[0], 1'b0);
      tick();
      tick();
      rst = 1'b0;
      clearObs();
      repeat (30) tick();
      checkOutput("post_rst_r_count", obs_r[0], 0);
      checkOutput("post_rst_s_count", obs_s[0], 0);

      // Input held high across reset release gives exactly one event.
      rst = 1'b1;
      applyStimulus(1'b1, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      clearObs();
      repeat (20) tick();
      checkOutput("held_thru_rst_s_count", obs_s[0], 1);
      checkOutput("held_thru_rst_first_s", first_s[0], 7);

      // Fast instance: clear wins a simultaneous pair, pulse after edge DEB_CYC+3.
      doReset();
      for (int e = 1; e <= 10; e++) begin
         applyStimulus(1'b1, 1'b1);
         tick();
      end
      checkOutput("fast_r_count", obs_r[1], 1);
      checkOutput("fast_first_r", first_r[1], 4);
      checkOutput("fast_s_count", obs_s[1], 0);
      checkOutput("fast_conflicts", obs_c[1], 1);

      // Two separate presses each give a pulse; releases give none.
      doReset();
      for (int e = 1; e <= 40; e++) begin
         applyStimulus((e <= 6) || (e >= 15 && e < 25), 1'b0);
         tick();
      end
      checkOutput("double_press_s_count", obs_s[0], 2);
      checkOutput("double_press_first_s", first_s[0], 7);

      // Random toggling with occasional resets, checked cycle by cycle against the model.
      doReset();
      for (int n = 0; n < 1500; n++) begin
         bit ns;
         bit nc;
         ns = set_req_async;
         nc = clr_req_async;
         if ($urandom_range(0, 6) == 0) ns = ~ns;
         if ($urandom_range(0, 6) == 0) nc = ~nc;
         applyStimulus(ns, nc);
         rst = ($urandom_range(0, 249) == 0);
         tick();
      end
      rst = 1'b0;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
